// File: rtl/dp_job_sequencer_pkg.sv
// Shared definitions for the DP job sequencer: default widths, the
// traceback timeout default and the controller state encoding.
package dp_job_sequencer_pkg;

  localparam int BP_WIDTH_DEF   = 2;
  localparam int LOG_N_DEF      = 7;
  localparam int TB_TIMEOUT_DEF = 65535;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_NEWSEQ   = 3'd1,
    ST_LOAD_S   = 3'd2,
    ST_STREAM_T = 3'd3,
    ST_WAIT_TB  = 3'd4,
    ST_ACK      = 3'd5
  } seq_state_e;

endpackage

// File: rtl/dp_seq_fifo2.sv
// Two-entry registered FIFO carrying reference bases toward the DP array.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module dp_seq_fifo2 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/dp_job_sequencer.sv
// Runs one alignment job on the DP + traceback top: new_seq pulse, query
// load, reference streaming under DP backpressure, traceback wait with
// alignment-beat counting, then ack and a done/err completion pulse.
module dp_job_sequencer
  import dp_job_sequencer_pkg::*;
#(
  parameter int BP_WIDTH   = BP_WIDTH_DEF,
  parameter int LOG_N      = LOG_N_DEF,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16,
  parameter int TB_TIMEOUT = TB_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                job_start,
  input  logic [LOG_N:0]      s_len,
  input  logic [ADDR_W-1:0]   t_len,
  output logic                job_busy,
  output logic                job_done,
  output logic                job_err,
  output logic [CNT_W-1:0]    aln_count,
  output logic [ADDR_W-1:0]   s_rd_addr,
  output logic                s_rd_en,
  input  logic [BP_WIDTH-1:0] s_rd_data,
  output logic [ADDR_W-1:0]   t_rd_addr,
  output logic                t_rd_en,
  input  logic [BP_WIDTH-1:0] t_rd_data,
  output logic [BP_WIDTH-1:0] dp_S,
  output logic                dp_s_update,
  output logic [BP_WIDTH-1:0] dp_T,
  output logic                dp_valid,
  output logic                dp_new_seq,
  output logic [LOG_N-1:0]    dp_PE_end,
  input  logic                dp_busy,
  output logic                dp_ack,
  input  logic                tb_done,
  input  logic                tb_aln_valid
);

  localparam int TMO_W = (TB_TIMEOUT > 1) ? $clog2(TB_TIMEOUT + 1) : 1;
  localparam logic [LOG_N:0] S_MAX = (LOG_N + 1)'(1) << LOG_N;

  seq_state_e          state_q, state_d;
  logic [LOG_N:0]      s_len_q;
  logic [ADDR_W-1:0]   t_len_q;
  logic [LOG_N-1:0]    pe_end_q;
  logic [ADDR_W-1:0]   s_addr_q;
  logic [ADDR_W-1:0]   t_addr_q;
  logic [ADDR_W-1:0]   t_xfer_q;
  logic                s_upd_q;
  logic                t_out_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [CNT_W-1:0]    aln_q;
  logic                err_flag_q;
  logic                job_busy_q;
  logic                job_done_q;
  logic                job_err_q;

  logic                start_ok, len_bad, tmo_hit, t_pop, t_room;
  logic                s_rd_en_c, t_rd_en_c, new_seq_c, ack_c;
  logic [BP_WIDTH-1:0] t_head;
  logic                t_full, t_empty;
  logic [1:0]          t_cnt;

  // A start arriving with a completion pulse belongs to the finishing job's
  // handshake window and is dropped rather than queued.
  assign start_ok = job_start && (state_q == ST_IDLE) && !job_done_q && !job_err_q;
  assign len_bad  = (s_len == '0) || (s_len > S_MAX) || (t_len == '0);
  assign tmo_hit  = (tmo_q == TMO_W'(TB_TIMEOUT - 1));
  assign t_pop    = (state_q == ST_STREAM_T) && !t_empty && !dp_busy;
  // Occupancy is taken after this cycle's pop so a steady stream needs no bubbles.
  assign t_room   = !(t_full && !t_pop) &&
                    (({1'b0, t_cnt} + {2'b00, t_out_q} - {2'b00, t_pop}) < 3'd2);

  dp_seq_fifo2 #(.W(BP_WIDTH)) u_t_fifo (
    .clk     (clk),
    .rst_i   (reset_i),
    .push_i  (t_out_q),
    .pop_i   (t_pop),
    .wdata_i (t_rd_data),
    .rdata_o (t_head),
    .full_o  (t_full),
    .empty_o (t_empty),
    .count_o (t_cnt)
  );

  // State register
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_d   = state_q;
    s_rd_en_c = 1'b0;
    t_rd_en_c = 1'b0;
    new_seq_c = 1'b0;
    ack_c     = 1'b0;
    unique case (state_q)
      ST_IDLE:     if (start_ok && !len_bad) state_d = ST_NEWSEQ;
      ST_NEWSEQ: begin
        new_seq_c = 1'b1;
        state_d   = ST_LOAD_S;
      end
      ST_LOAD_S: begin
        s_rd_en_c = (s_addr_q < ADDR_W'(s_len_q));
        if (s_upd_q && (s_addr_q == ADDR_W'(s_len_q))) state_d = ST_STREAM_T;
      end
      ST_STREAM_T: begin
        t_rd_en_c = (t_addr_q < t_len_q) && t_room;
        if (t_pop && (t_xfer_q == t_len_q - ADDR_W'(1))) state_d = ST_WAIT_TB;
      end
      ST_WAIT_TB:  if (tb_done || tmo_hit) state_d = ST_ACK;
      ST_ACK: begin
        ack_c   = 1'b1;
        state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // Job bookkeeping: lengths, address/beat counters, timeout, alignment count
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      s_len_q    <= '0;
      t_len_q    <= '0;
      pe_end_q   <= '0;
      s_addr_q   <= '0;
      t_addr_q   <= '0;
      t_xfer_q   <= '0;
      s_upd_q    <= 1'b0;
      t_out_q    <= 1'b0;
      tmo_q      <= '0;
      aln_q      <= '0;
      err_flag_q <= 1'b0;
      job_busy_q <= 1'b0;
      job_done_q <= 1'b0;
      job_err_q  <= 1'b0;
    end else begin
      job_done_q <= 1'b0;
      job_err_q  <= 1'b0;
      s_upd_q    <= s_rd_en_c;
      t_out_q    <= t_rd_en_c;
      if (s_rd_en_c) s_addr_q <= s_addr_q + ADDR_W'(1);
      if (t_rd_en_c) t_addr_q <= t_addr_q + ADDR_W'(1);
      if (t_pop)     t_xfer_q <= t_xfer_q + ADDR_W'(1);
      if (start_ok) begin
        if (len_bad) begin
          job_err_q <= 1'b1;
        end else begin
          s_len_q    <= s_len;
          t_len_q    <= t_len;
          pe_end_q   <= LOG_N'(s_len - (LOG_N + 1)'(1));
          s_addr_q   <= '0;
          t_addr_q   <= '0;
          t_xfer_q   <= '0;
          tmo_q      <= '0;
          aln_q      <= '0;
          err_flag_q <= 1'b0;
          job_busy_q <= 1'b1;
        end
      end
      if (state_q == ST_WAIT_TB) begin
        tmo_q <= tmo_q + TMO_W'(1);
        if (tb_aln_valid && (aln_q != '1)) aln_q <= aln_q + CNT_W'(1);
        if (tmo_hit && !tb_done) err_flag_q <= 1'b1;
      end
      if (state_q == ST_ACK) begin
        job_busy_q <= 1'b0;
        job_done_q <= !err_flag_q;
        job_err_q  <= err_flag_q;
        pe_end_q   <= '0;
      end
    end
  end

  assign job_busy    = job_busy_q;
  assign job_done    = job_done_q;
  assign job_err     = job_err_q;
  assign aln_count   = aln_q;
  assign s_rd_en     = s_rd_en_c;
  assign s_rd_addr   = s_rd_en_c ? s_addr_q : '0;
  assign t_rd_en     = t_rd_en_c;
  assign t_rd_addr   = t_rd_en_c ? t_addr_q : '0;
  assign dp_S        = s_upd_q ? s_rd_data : '0;
  assign dp_s_update = s_upd_q;
  assign dp_T        = t_empty ? '0 : t_head;
  assign dp_valid    = !t_empty;
  assign dp_new_seq  = new_seq_c;
  assign dp_PE_end   = pe_end_q;
  assign dp_ack      = ack_c;

endmodule

// File: tb/tb_dp_job_sequencer.sv
// Scoreboard bench for dp_job_sequencer: directed jobs push expected beats
// and completion events; a negedge monitor pops and compares them.
module tb_dp_job_sequencer;

  localparam int TMO = 50;

  typedef struct {
    bit err;
    bit chk_aln;
    int aln;
  } ev_t;

  logic        clk, reset_i, job_start;
  logic [7:0]  s_len;
  logic [15:0] t_len;
  logic        job_busy, job_done, job_err;
  logic [15:0] aln_count, s_rd_addr, t_rd_addr;
  logic        s_rd_en, t_rd_en;
  logic [1:0]  s_rd_data, t_rd_data, dp_S, dp_T;
  logic        dp_s_update, dp_valid, dp_new_seq, dp_busy, dp_ack;
  logic [6:0]  dp_PE_end;
  logic        tb_done, tb_aln_valid;

  int cnt_cmp = 0, cnt_bad = 0;
  int cyc = 0, n_newseq = 0, n_supd = 0, n_tx = 0, n_ack = 0, n_fin = 0;
  int n_busy = 0, n_strobe = 0;
  int first_tx = 0, last_tx = 0, last_ack = 0;
  bit first_pend = 0;
  logic [15:0] cur_tl = '0;
  logic [6:0]  cur_pe = '0;

  logic [1:0] exp_s[$];
  logic [1:0] exp_t[$];
  logic [6:0] exp_pe[$];
  ev_t        exp_ev[$];
  ev_t        mon_ev;

  dp_job_sequencer #(.TB_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_i(reset_i), .job_start(job_start), .s_len(s_len), .t_len(t_len),
    .job_busy(job_busy), .job_done(job_done), .job_err(job_err), .aln_count(aln_count),
    .s_rd_addr(s_rd_addr), .s_rd_en(s_rd_en), .s_rd_data(s_rd_data),
    .t_rd_addr(t_rd_addr), .t_rd_en(t_rd_en), .t_rd_data(t_rd_data),
    .dp_S(dp_S), .dp_s_update(dp_s_update), .dp_T(dp_T), .dp_valid(dp_valid),
    .dp_new_seq(dp_new_seq), .dp_PE_end(dp_PE_end), .dp_busy(dp_busy), .dp_ack(dp_ack),
    .tb_done(tb_done), .tb_aln_valid(tb_aln_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] s_val(input int i);
    return 2'(i + (i >> 2));
  endfunction

  function automatic logic [1:0] t_val(input int i);
    return 2'(3 * i + (i >> 1));
  endfunction

  // Sequence buffers: read data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (s_rd_en) s_rd_data <= s_val(int'(s_rd_addr));
    if (t_rd_en) t_rd_data <= t_val(int'(t_rd_addr));
  end

  task automatic chk(input string nm, input int act, input int req);
    cnt_cmp++;
    if (act !== req) begin
      cnt_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic logic out_any();
    return |{job_busy, job_done, job_err, aln_count, s_rd_addr, s_rd_en, t_rd_addr, t_rd_en,
             dp_S, dp_s_update, dp_T, dp_valid, dp_new_seq, dp_PE_end, dp_ack};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every DUT presentation against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!reset_i) begin
      if (job_busy) n_busy++;
      if (s_rd_en || t_rd_en || dp_valid || dp_ack || dp_new_seq || dp_s_update) n_strobe++;
      if (dp_new_seq) begin
        n_newseq++;
        first_pend = 1'b1;
        if (exp_pe.size() == 0) chk("newseq_unexpected", 1, 0);
        else chk("pe_end", int'(dp_PE_end), int'(exp_pe.pop_front()));
      end
      if (dp_s_update) begin
        n_supd++;
        if (exp_s.size() == 0) chk("s_unexpected", int'(dp_S), -1);
        else chk("s_beat", int'(dp_S), int'(exp_s.pop_front()));
      end
      if (t_rd_en) chk("t_rd_range", int'(t_rd_addr < cur_tl), 1);
      if (dp_valid) begin
        chk("pe_hold", int'(dp_PE_end), int'(cur_pe));
        if (exp_t.size() == 0) begin
          chk("t_unexpected", int'(dp_T), -1);
        end else if (dp_busy) begin
          chk("t_hold", int'(dp_T), int'(exp_t[0]));
        end else begin
          chk("t_beat", int'(dp_T), int'(exp_t.pop_front()));
          n_tx++;
          if (first_pend) begin
            first_tx   = cyc;
            first_pend = 1'b0;
          end
          last_tx = cyc;
        end
      end
      if (dp_ack) begin
        n_ack++;
        last_ack = cyc;
      end
      if (job_done || job_err) begin
        n_fin++;
        if (exp_ev.size() == 0) begin
          chk("fin_unexpected", 1, 0);
        end else begin
          mon_ev = exp_ev.pop_front();
          chk("fin_err", int'(job_err), int'(mon_ev.err));
          chk("fin_done", int'(job_done), int'(!mon_ev.err));
          chk("fin_busy", int'(job_busy), 0);
          if (mon_ev.chk_aln) chk("aln_count", int'(aln_count), mon_ev.aln);
        end
      end
    end
  end

  task automatic run_job(input int sl, input int tl, input int stall_at, input int delay,
                         input int naln, input bit tmo, input bit bs, input bit ds);
    int b_ns, b_su, b_tx, b_ack, b_fin, hold, k;
    bit stalled, bs_fired, ds_fired;
    b_ns = n_newseq; b_su = n_supd; b_tx = n_tx; b_ack = n_ack; b_fin = n_fin;
    for (int i = 0; i < sl; i++) exp_s.push_back(s_val(i));
    for (int i = 0; i < tl; i++) exp_t.push_back(t_val(i));
    exp_pe.push_back(7'(sl - 1));
    exp_ev.push_back('{tmo, 1'b1, naln});
    cur_tl = 16'(tl);
    cur_pe = 7'(sl - 1);
    s_len = 8'(sl); t_len = 16'(tl); job_start = 1'b1;
    step();
    job_start = 1'b0;
    k = 0; hold = 0; stalled = 1'b0; bs_fired = 1'b0;
    while ((n_tx - b_tx < tl) && (k < 3000)) begin
      job_start = 1'b0;
      if (bs && !bs_fired && (n_supd - b_su >= 10)) begin
        job_start = 1'b1; s_len = 8'd4; t_len = 16'd4; bs_fired = 1'b1;
      end
      if (stall_at >= 0 && !stalled && (n_tx - b_tx >= stall_at)) begin
        dp_busy = 1'b1; stalled = 1'b1; hold = 3;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) dp_busy = 1'b0;
      end
      step();
      k++;
    end
    job_start = 1'b0;
    dp_busy = 1'b0;
    chk("stream_beats", n_tx - b_tx, tl);
    for (int j = 0; j < delay; j++) begin
      tb_aln_valid = (j >= delay - naln);
      tb_done      = !tmo && (j == delay - 1);
      step();
    end
    tb_aln_valid = 1'b0;
    tb_done = 1'b0;
    k = 0; ds_fired = 1'b0;
    while ((n_fin == b_fin) && (k < 200)) begin
      job_start = 1'b0;
      if (ds && !ds_fired && (n_ack != b_ack)) begin
        job_start = 1'b1; s_len = 8'd2; t_len = 16'd2; ds_fired = 1'b1;
      end
      step();
      k++;
    end
    job_start = 1'b0;
    chk("fin_count", n_fin - b_fin, 1);
    chk("newseq_cycles", n_newseq - b_ns, 1);
    chk("s_update_beats", n_supd - b_su, sl);
    chk("ack_cycles", n_ack - b_ack, 1);
    if (stall_at < 0) chk("t_consecutive_span", last_tx - first_tx, tl - 1);
    else              chk("t_stall_span", last_tx - first_tx, tl - 1 + 3);
    if (tmo) chk("timeout_ack_latency", last_ack - last_tx, TMO + 1);
    repeat (6) step();
    chk("idle_after_job", int'(job_busy), 0);
    chk("no_restart", n_newseq - b_ns, 1);
  endtask

  task automatic reject(input int sl, input int tl);
    int b_ns, b_fin, b_busy, b_str;
    b_ns = n_newseq; b_fin = n_fin; b_busy = n_busy; b_str = n_strobe;
    exp_ev.push_back('{1'b1, 1'b0, 0});
    s_len = 8'(sl); t_len = 16'(tl); job_start = 1'b1;
    step();
    job_start = 1'b0;
    repeat (4) step();
    chk("rej_err_pulses", n_fin - b_fin, 1);
    chk("rej_newseq", n_newseq - b_ns, 0);
    chk("rej_busy_cycles", n_busy - b_busy, 0);
    chk("rej_dp_strobes", n_strobe - b_str, 0);
  endtask

  initial begin
    int b_tx, b_fin, k;
    reset_i = 1'b1; job_start = 1'b0; s_len = '0; t_len = '0;
    dp_busy = 1'b0; tb_done = 1'b0; tb_aln_valid = 1'b0;
    repeat (3) step();
    chk("reset_outputs_zero", int'(out_any()), 0);
    reset_i = 1'b0;
    step();

    // Basic job; a start on the done-pulse cycle must be dropped.
    run_job(4, 6, -1, 20, 3, 1'b0, 1'b0, 1'b1);
    // Backpressure mid-stream.
    run_job(2, 5, 2, 4, 1, 1'b0, 1'b0, 1'b0);
    // Rejected starts.
    reject(0, 4);
    reject(4, 0);
    reject(129, 4);
    // Traceback never completes.
    run_job(3, 2, -1, 5, 2, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of the reference stream.
    b_tx = n_tx; b_fin = n_fin;
    for (int i = 0; i < 3; i++) exp_s.push_back(s_val(i));
    for (int i = 0; i < 8; i++) exp_t.push_back(t_val(i));
    exp_pe.push_back(7'd2);
    exp_ev.push_back('{1'b0, 1'b1, 0});
    cur_tl = 16'd8; cur_pe = 7'd2;
    s_len = 8'd3; t_len = 16'd8; job_start = 1'b1;
    step();
    job_start = 1'b0;
    k = 0;
    while ((n_tx - b_tx < 2) && (k < 500)) begin
      step();
      k++;
    end
    chk("pre_reset_stream", int'(n_tx - b_tx >= 2), 1);
    #3;
    reset_i = 1'b1;
    #1;
    chk("async_reset_outputs_zero", int'(out_any()), 0);
    exp_s.delete(); exp_t.delete(); exp_pe.delete(); exp_ev.delete();
    step();
    step();
    reset_i = 1'b0;
    step();
    chk("reset_no_completion", n_fin - b_fin, 0);
    run_job(5, 4, -1, 5, 1, 1'b0, 1'b0, 1'b0);

    // Maximum query length; a start while busy must be dropped.
    run_job(128, 3, -1, 3, 0, 1'b0, 1'b1, 1'b0);

    chk("s_queue_empty", exp_s.size(), 0);
    chk("t_queue_empty", exp_t.size(), 0);
    chk("ev_queue_empty", exp_ev.size(), 0);
    chk("pe_queue_empty", exp_pe.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dp_job_sequencer.md
Name: dp_job_sequencer

Overview:
- Controller that runs one alignment job on the DP + traceback top.
- Per job: pulses new_seq, loads the query S from a local buffer, and streams the reference T with backpressure from DP busy.
- Then waits for traceback done, counts alignment beats, and releases the DP with ack.
- Sits between the host-side sequence buffers/job registers and the DP top.

Parameters:
- BP_WIDTH, 2, bits per base (matches `BP_WIDTH)
- LOG_N, 7, PE index width; max query length 2**LOG_N
- ADDR_W, 16, sequence buffer address width
- CNT_W, 16, alignment beat counter width
- TB_TIMEOUT, 65535, max cycles in WAIT_TB before abort

Ports:
- clk  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- job_start  in  1  start pulse; ignored unless idle
- s_len  in  LOG_N+1  query length, 1..2**LOG_N, sampled at job_start
- t_len  in  ADDR_W  reference length, >=1, sampled at job_start
- job_busy  out  1  high from accepted start until job_done/job_err
- job_done  out  1  one-cycle pulse on normal completion
- job_err  out  1  one-cycle pulse on rejected start or timeout
- aln_count  out  CNT_W  alignment_valid beats counted for the last job
- s_rd_addr  out  ADDR_W  query buffer read address
- s_rd_en  out  1  query buffer read strobe
- s_rd_data  in  BP_WIDTH  query base, valid 1 cycle after s_rd_en
- t_rd_addr  out  ADDR_W  reference buffer read address
- t_rd_en  out  1  reference buffer read strobe
- t_rd_data  in  BP_WIDTH  reference base, valid 1 cycle after t_rd_en
- dp_S  out  BP_WIDTH  to DP S
- dp_s_update  out  1  to DP s_update
- dp_T  out  BP_WIDTH  to DP T
- dp_valid  out  1  to DP valid
- dp_new_seq  out  1  to DP new_seq
- dp_PE_end  out  LOG_N  to DP PE_end
- dp_busy  in  1  from DP busy
- dp_ack  out  1  to DP ack
- tb_done  in  1  traceback done
- tb_aln_valid  in  1  traceback alignment_valid

Behaviour:
- Reset (async, reset_i=1): state IDLE; every output 0; counters and FIFO cleared. Reset mid-job abandons the job with no job_done/job_err pulse.
- FSM: IDLE -> NEWSEQ -> LOAD_S -> STREAM_T -> WAIT_TB -> ACK -> IDLE.
- IDLE:
  - On job_start with s_len==0, s_len>2**LOG_N or t_len==0: job_err pulse next cycle, remain IDLE.
  - Otherwise latch lengths, set job_busy=1, clear aln_count, go to NEWSEQ.
- NEWSEQ (1 cycle):
  - dp_new_seq=1.
  - dp_PE_end=s_len-1, held constant until job end.
- LOAD_S:
  - Issue s_rd_en with address 0..s_len-1 on consecutive cycles.
  - Each returning beat drives dp_S=s_rd_data with dp_s_update=1, one cycle after its read.
  - No stalls.
  - Exit after the last s_update beat.
- STREAM_T:
  - A beat transfers on a cycle with dp_valid=1 and dp_busy=0.
  - dp_T/dp_valid come from the head of t_fifo (2 entries, registered). dp_valid = fifo non-empty; a beat is held stable while dp_busy=1.
  - A read is issued when occupancy + outstanding < 2 and addresses remain (addresses 0..t_len-1).
  - Read data is pushed into t_fifo one cycle after the read.
  - Exit when t_len beats have transferred.
- WAIT_TB:
  - Each tb_aln_valid cycle increments aln_count, saturating at 2**CNT_W-1; counting is active only in this state.
  - tb_done -> ACK.
  - TB_TIMEOUT cycles without tb_done -> ACK with an error flag set.
- ACK (1 cycle):
  - dp_ack=1.
  - Next cycle: job_done (or job_err if flagged) pulses, job_busy falls, state returns to IDLE.
- Simultaneous events:
  - tb_aln_valid on the same cycle as tb_done is counted.
  - job_start on the same cycle as the job_done pulse is ignored.
- Width rules: s_len compare uses LOG_N+1 bits; PE_end truncates s_len-1 to LOG_N bits (valid since s_len<=2**LOG_N).

Decomposition:
- Shared package holds BP_WIDTH, LOG_N, the FSM state encoding (3-bit enum) and a TB_TIMEOUT default.
- One sub-module, dp_seq_fifo2: a 2-entry registered FIFO with push, pop, full, empty and count; used for the T stream.

Test Plan:
- s_len=4, t_len=6, dp_busy=0, tb_done 20 cycles later with 3 tb_aln_valid -> dp_new_seq 1 cycle; dp_PE_end=3; 4 s_update beats in buffer order; 6 valid beats on consecutive cycles; dp_ack 1 cycle; job_done pulse; aln_count=3.
- t_len=5, dp_busy high for 3 cycles mid-stream -> dp_T held stable while busy; no beat lost or duplicated; exactly 5 transfers in order.
- job_start with s_len=0 (and separately t_len=0) -> job_err pulse, job_busy stays 0, no DP strobes.
- tb_done never asserted, TB_TIMEOUT=50 -> dp_ack after 50 WAIT_TB cycles, then job_err pulse, back to IDLE.
- reset_i asserted asynchronously during STREAM_T -> all outputs 0 immediately; a new job then runs cleanly from address 0.
- s_len=128 (2**LOG_N) -> dp_PE_end=127; 128 s_update beats; job_start during busy ignored.
